// File: rtl/sb_cfg_switch_if.sv
// Track and configuration bundle for the switch box.
// master drives inputs/config; slave is the switch box.
interface sb_cfg_switch_if #(
  parameter int W = 4
);
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] in3;
  logic [W-1:0] in4;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] out3;
  logic [W-1:0] out4;
  logic         cfg_en;
  logic         cfg_din;
  logic         cfg_commit;
  logic         cfg_full;
  logic         cfg_ack;
  logic         cfg_err;

  modport master (
    output in1, in2, in3, in4,
    output cfg_en, cfg_din, cfg_commit,
    input  out1, out2, out3, out4,
    input  cfg_full, cfg_ack, cfg_err
  );

  modport slave (
    input  in1, in2, in3, in4,
    input  cfg_en, cfg_din, cfg_commit,
    output out1, out2, out3, out4,
    output cfg_full, cfg_ack, cfg_err
  );
endinterface

// File: rtl/sb_cfg_switch.sv
// Four-sided routing switch box, serial shadow config, atomic commit.
// Ports: clk, rst_n (sync, active-low), bus (sb_cfg_switch_if.slave).
module sb_cfg_switch #(
  parameter int W = 4
) (
  input logic          clk,
  input logic          rst_n,
  sb_cfg_switch_if.slave bus
);

  localparam int CFG_BITS = 8*W + 4;
  localparam int CW = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    FULL
  } state_t;

  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [CFG_BITS-1:0]   r_shadow, w_shadow;
  logic [CFG_BITS-1:0]   r_active, w_active;
  logic                  r_ack, w_ack;
  logic                  r_err, w_err;
  logic                  r_full;
  logic [3:0][W-1:0]     r_oreg;
  logic [3:0][W-1:0]     w_in;
  logic [3:0][W-1:0]     w_mux;

  assign w_in[0] = bus.in1;
  assign w_in[1] = bus.in2;
  assign w_in[2] = bus.in3;
  assign w_in[3] = bus.in4;

  // Sources of side k are the other sides in ascending order,
  // so source m is side m when m<k and side m+1 otherwise.
  always_comb begin
    w_mux = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < W; j++) begin
        logic [1:0] v_sel;
        v_sel = r_active[CFG_BITS-1-2*(k*W+j) -: 2];
        unique case (v_sel)
          2'd0: w_mux[k][j] = w_in[(k > 0) ? 0 : 1][j];
          2'd1: w_mux[k][j] = w_in[(k > 1) ? 1 : 2][j];
          2'd2: w_mux[k][j] = w_in[(k > 2) ? 2 : 3][j];
          2'd3: w_mux[k][j] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_shadow = r_shadow;
    w_active = r_active;
    w_ack    = 1'b0;
    w_err    = 1'b0;
    unique case (1'b1)
      (bus.cfg_en && bus.cfg_commit): w_err = 1'b1;
      (bus.cfg_commit && !bus.cfg_en): begin
        if (r_state == FULL) begin
          w_active = r_shadow;
          w_ack    = 1'b1;
          w_cnt    = '0;
          w_state  = EMPTY;
        end else begin
          w_err = 1'b1;
        end
      end
      (bus.cfg_en && !bus.cfg_commit): begin
        if (r_state == FULL) begin
          w_err = 1'b1;
        end else begin
          w_shadow = {r_shadow[CFG_BITS-2:0], bus.cfg_din};
          w_cnt    = r_cnt + CW'(1);
          w_state  = (w_cnt == CW'(CFG_BITS)) ? FULL : LOADING;
        end
      end
      default: ;
    endcase
    if (w_err) begin
      w_shadow = '0;
      w_cnt    = '0;
      w_state  = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= {{(8*W){1'b1}}, 4'b0000};
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_full   <= 1'b0;
      r_oreg   <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_shadow <= w_shadow;
      r_active <= w_active;
      r_ack    <= w_ack;
      r_err    <= w_err;
      r_full   <= (w_state == FULL);
      r_oreg   <= w_mux;
    end
  end

  assign bus.out1 = r_active[0] ? r_oreg[0] : w_mux[0];
  assign bus.out2 = r_active[1] ? r_oreg[1] : w_mux[1];
  assign bus.out3 = r_active[2] ? r_oreg[2] : w_mux[2];
  assign bus.out4 = r_active[3] ? r_oreg[3] : w_mux[3];
  assign bus.cfg_full = r_full;
  assign bus.cfg_ack  = r_ack;
  assign bus.cfg_err  = r_err;

endmodule
